// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op-class helpers for alu_seq.
// ALU_ROTATE_EN enables the ROL/ROR ops (12, 13).
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLT = 4'd6,
        OP_EQ  = 4'd7,
        OP_SLL = 4'd8,
        OP_SRL = 4'd9,
        OP_SRA = 4'd10,
        OP_MUL = 4'd11,
        OP_ROL = 4'd12,
        OP_ROR = 4'd13,
        OP_R14 = 4'd14,
        OP_R15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } alu_state_e;

    function automatic logic is_legal(alu_op_e op);
`ifdef ALU_ROTATE_EN
        return (op <= OP_ROR);
`else
        return (op <= OP_MUL);
`endif
    endfunction

    // Ops sequenced through BUSY (shift by n>0, multiply).
    function automatic logic is_multicycle(alu_op_e op);
        logic r;
        r = 1'b0;
        unique case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_MUL: r = 1'b1;
`ifdef ALU_ROTATE_EN
            OP_ROL, OP_ROR: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: valid/ready operand and result bundle of alu_seq.
// master = producer/consumer side, slave = the ALU.
interface alu_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             in_c;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_c;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, op, in_c, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_s, out_c,
        input  zero, overflow, illegal
    );

    modport slave (
        input  in_valid, op, in_c, in_x, in_y, out_ready,
        output in_ready, out_valid, out_s, out_c,
        output zero, overflow, illegal
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle datapath (add/sub, logic, SLT, EQ).
// Ports: op_i, x_i, y_i, c_i in; s_o result, c_o carry, ovf_o overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o
);

    logic             is_sub;
    logic [WIDTH-1:0] yb;
    logic             cin;
    logic [WIDTH:0]   sum;

    // SUB reuses the adder as x + ~y + 1.
    assign is_sub = (op_i == OP_SUB);
    assign yb     = is_sub ? ~y_i : y_i;
    assign cin    = is_sub ? 1'b1 : c_i;
    assign sum    = {1'b0, x_i} + {1'b0, yb}
                  + {{WIDTH{1'b0}}, cin};

    always_comb begin
        s_o   = '0;
        c_o   = 1'b0;
        ovf_o = 1'b0;
        unique case (op_i)
            OP_ADD, OP_SUB: begin
                s_o   = sum[WIDTH-1:0];
                c_o   = sum[WIDTH];
                ovf_o = (x_i[WIDTH-1] == yb[WIDTH-1])
                     && (sum[WIDTH-1] != x_i[WIDTH-1]);
            end
            OP_NOT: s_o = ~x_i;
            OP_AND: s_o = x_i & y_i;
            OP_OR:  s_o = x_i | y_i;
            OP_XOR: s_o = x_i ^ y_i;
            OP_SLT: s_o = {{(WIDTH-1){1'b0}},
                           ($signed(x_i) < $signed(y_i))};
            OP_EQ:  s_o = {{(WIDTH-1){1'b0}}, (x_i == y_i)};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; iterative shifts/multiply via IDLE/BUSY/DONE FSM.
// Ports: clk, rst (sync, active-high), bus (alu_if.slave). Macro: ALU_ROTATE_EN.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    alu_state_e         state_q;
    alu_op_e            op_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   mp_q;
    logic [2*WIDTH-1:0] mc_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   s_q;
    logic               c_q;
    logic               z_q;
    logic               ov_q;
    logic               il_q;

    alu_op_e            op_in;
    logic [SHW-1:0]     amt;
    logic [WIDTH-1:0]   core_s;
    logic               core_c;
    logic               core_ov;

    logic [WIDTH-1:0]   sh_d;
    logic               shc_d;
    logic [2*WIDTH-1:0] prod_d;

    assign op_in = alu_op_e'(bus.op);
    assign amt   = bus.in_y[SHW-1:0];

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i  (op_in),
        .x_i   (bus.in_x),
        .y_i   (bus.in_y),
        .c_i   (bus.in_c),
        .s_o   (core_s),
        .c_o   (core_c),
        .ovf_o (core_ov)
    );

    // One bit-step of the in-flight shift/rotate and shift-add multiply.
    always_comb begin
        sh_d  = sh_q;
        shc_d = 1'b0;
        unique case (op_q)
            OP_SLL: begin
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                shc_d = sh_q[WIDTH-1];
            end
            OP_SRL: begin
                sh_d  = {1'b0, sh_q[WIDTH-1:1]};
                shc_d = sh_q[0];
            end
            OP_SRA: begin
                sh_d  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                shc_d = sh_q[0];
            end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin
                sh_d  = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
                shc_d = sh_q[WIDTH-1];
            end
            OP_ROR: begin
                sh_d  = {sh_q[0], sh_q[WIDTH-1:1]};
                shc_d = sh_q[0];
            end
`endif
            default: ;
        endcase
        prod_d = mp_q[0] ? (prod_q + mc_q) : prod_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            sh_q    <= '0;
            mp_q    <= '0;
            mc_q    <= '0;
            prod_q  <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            il_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= op_in;
                        if (!is_legal(op_in)) begin
                            s_q     <= '0;
                            c_q     <= 1'b0;
                            z_q     <= 1'b1;
                            ov_q    <= 1'b0;
                            il_q    <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (op_in == OP_MUL) begin
                            mc_q    <= {{WIDTH{1'b0}}, bus.in_x};
                            mp_q    <= bus.in_y;
                            prod_q  <= '0;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= ST_BUSY;
                        end else if (is_multicycle(op_in)) begin
                            if (amt == '0) begin
                                s_q     <= bus.in_x;
                                c_q     <= 1'b0;
                                z_q     <= (bus.in_x == '0);
                                ov_q    <= 1'b0;
                                il_q    <= 1'b0;
                                state_q <= ST_DONE;
                            end else begin
                                sh_q    <= bus.in_x;
                                cnt_q   <= {1'b0, amt};
                                state_q <= ST_BUSY;
                            end
                        end else begin
                            s_q     <= core_s;
                            c_q     <= core_c;
                            z_q     <= (core_s == '0);
                            ov_q    <= core_ov;
                            il_q    <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_q  <= cnt_q - CW'(1);
                    sh_q   <= sh_d;
                    prod_q <= prod_d;
                    mc_q   <= {mc_q[2*WIDTH-2:0], 1'b0};
                    mp_q   <= {1'b0, mp_q[WIDTH-1:1]};
                    if (cnt_q == CW'(1)) begin
                        ov_q    <= 1'b0;
                        il_q    <= 1'b0;
                        state_q <= ST_DONE;
                        if (op_q == OP_MUL) begin
                            s_q <= prod_d[WIDTH-1:0];
                            c_q <= |prod_d[2*WIDTH-1:WIDTH];
                            z_q <= (prod_d[WIDTH-1:0] == '0);
                        end else begin
                            s_q <= sh_d;
                            c_q <= shc_d;
                            z_q <= (sh_d == '0);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !rst && (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_s     = s_q;
    assign bus.out_c     = c_q;
    assign bus.zero      = z_q;
    assign bus.overflow  = ov_q;
    assign bus.illegal   = il_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table + scoreboard bench for alu_seq (WIDTH=8).
// Adds hand sequences for back-pressure and mid-op reset.
module tb_alu_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       z;
        logic       ov;
        logic       il;
        int         lat;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic addv(string nm, logic [3:0] op, logic [7:0] x,
                        logic [7:0] y, logic c, logic [7:0] s,
                        logic co, logic z, logic ov, logic il,
                        int lat);
        vec_t v;
        v.name = nm; v.op = op; v.x = x; v.y = y; v.c = c;
        v.s = s; v.co = co; v.z = z; v.ov = ov; v.il = il;
        v.lat = lat;
        vt.push_back(v);
    endtask

    // Drive one op, push its expectation, wait for and check the result.
    task automatic run(vec_t v, logic release_out);
        int   n;
        int   lat;
        vec_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = v.op;
        bus.in_x     = v.x;
        bus.in_y     = v.y;
        bus.in_c     = v.c;
        @(posedge clk);
        sb.push_back(v);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x     = 8'($urandom);
        bus.in_y     = 8'($urandom);
        bus.in_c     = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            failures++;
            checks++;
            $display("FAIL %s timeout actual=no_out_valid expected=out_valid",
                     v.name);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".s"},   32'(bus.out_s),    32'(e.s));
        chk({e.name, ".c"},   32'(bus.out_c),    32'(e.co));
        chk({e.name, ".z"},   32'(bus.zero),     32'(e.z));
        chk({e.name, ".ov"},  32'(bus.overflow), 32'(e.ov));
        chk({e.name, ".il"},  32'(bus.illegal),  32'(e.il));
        chk({e.name, ".lat"}, 32'(lat),          32'(e.lat));
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    vec_t h;
    int   ov_seen;

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_c      = 1'b0;
        bus.out_ready = 1'b0;

        addv("add_ovf",  4'd0,  8'h7F, 8'h01, 0, 8'h80, 0, 0, 1, 0, 1);
        addv("add_wrap", 4'd0,  8'hFF, 8'h01, 0, 8'h00, 1, 1, 0, 0, 1);
        addv("add_cin",  4'd0,  8'h10, 8'h20, 1, 8'h31, 0, 0, 0, 0, 1);
        addv("sub_eq",   4'd1,  8'h05, 8'h05, 0, 8'h00, 1, 1, 0, 0, 1);
        addv("sub_brw",  4'd1,  8'h00, 8'h01, 1, 8'hFF, 0, 0, 0, 0, 1);
        addv("sub_ovf",  4'd1,  8'h80, 8'h01, 0, 8'h7F, 1, 0, 1, 0, 1);
        addv("not",      4'd2,  8'h0F, 8'h00, 0, 8'hF0, 0, 0, 0, 0, 1);
        addv("and",      4'd3,  8'hF0, 8'h3C, 0, 8'h30, 0, 0, 0, 0, 1);
        addv("or",       4'd4,  8'hF0, 8'h0F, 0, 8'hFF, 0, 0, 0, 0, 1);
        addv("xor",      4'd5,  8'hFF, 8'hFF, 0, 8'h00, 0, 1, 0, 0, 1);
        addv("slt_t",    4'd6,  8'hFE, 8'h01, 0, 8'h01, 0, 0, 0, 0, 1);
        addv("slt_f",    4'd6,  8'h01, 8'hFE, 0, 8'h00, 0, 1, 0, 0, 1);
        addv("eq_t",     4'd7,  8'h05, 8'h05, 0, 8'h01, 0, 0, 0, 0, 1);
        addv("eq_f",     4'd7,  8'h05, 8'h06, 0, 8'h00, 0, 1, 0, 0, 1);
        addv("sll3",     4'd8,  8'h81, 8'h03, 0, 8'h08, 0, 0, 0, 0, 4);
        addv("sll0",     4'd8,  8'h81, 8'h00, 0, 8'h81, 0, 0, 0, 0, 1);
        addv("sll_amt9", 4'd8,  8'h01, 8'h09, 0, 8'h02, 0, 0, 0, 0, 2);
        addv("srl4",     4'd9,  8'h81, 8'h04, 0, 8'h08, 0, 0, 0, 0, 5);
        addv("sra1",     4'd10, 8'h81, 8'h01, 0, 8'hC0, 1, 0, 0, 0, 2);
        addv("sra7",     4'd10, 8'h40, 8'h07, 0, 8'h00, 1, 1, 0, 0, 8);
        addv("mul_a",    4'd11, 8'h10, 8'h11, 0, 8'h10, 1, 0, 0, 0, 9);
        addv("mul_b",    4'd11, 8'h0D, 8'h0B, 0, 8'h8F, 0, 0, 0, 0, 9);
        addv("mul_ff",   4'd11, 8'hFF, 8'hFF, 0, 8'h01, 1, 0, 0, 0, 9);
`ifdef ALU_ROTATE_EN
        addv("rol1",     4'd12, 8'h81, 8'h01, 0, 8'h03, 1, 0, 0, 0, 2);
        addv("ror2",     4'd13, 8'h81, 8'h02, 0, 8'h60, 0, 0, 0, 0, 3);
`else
        addv("ill_c",    4'd12, 8'h12, 8'h34, 0, 8'h00, 0, 1, 0, 1, 1);
        addv("ill_d",    4'd13, 8'h12, 8'h01, 0, 8'h00, 0, 1, 0, 1, 1);
`endif
        addv("ill_f",    4'd15, 8'hAA, 8'h55, 1, 8'h00, 0, 1, 0, 1, 1);

        repeat (2) @(negedge clk);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_s",     32'(bus.out_s),     32'd0);
        chk("rst.flags",     32'({bus.out_c, bus.zero,
                                  bus.overflow, bus.illegal}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.in_ready_after", 32'(bus.in_ready), 32'd1);

        foreach (vt[i]) run(vt[i], 1'b1);

        // Back-pressure: result held, in_valid pulses ignored.
        h.name = "bp"; h.op = 4'd0; h.x = 8'h01; h.y = 8'h02;
        h.c = 0; h.s = 8'h03; h.co = 0; h.z = 0; h.ov = 0;
        h.il = 0; h.lat = 1;
        run(h, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k == 1 || k == 2);
            bus.op       = 4'd5;
            bus.in_x     = 8'hFF;
            bus.in_y     = 8'h0F;
            @(negedge clk);
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.out_s",     32'(bus.out_s),     32'h03);
            chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp.idle_valid", 32'(bus.out_valid), 32'd0);
        chk("bp.idle_ready", 32'(bus.in_ready),  32'd1);
        ov_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen++;
        end
        chk("bp.no_ghost", 32'(ov_seen), 32'd0);

        // Reset during BUSY cycle 4 of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 4'd11;
        bus.in_x     = 8'h10;
        bus.in_y     = 8'h11;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mr.busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mr.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr.out_s",     32'(bus.out_s),     32'd0);
        chk("mr.flags",     32'({bus.out_c, bus.zero,
                                 bus.overflow, bus.illegal}), 32'd0);
        chk("mr.in_ready_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("mr.in_ready", 32'(bus.in_ready), 32'd1);
        ov_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen++;
        end
        chk("mr.aborted", 32'(ov_seen), 32'd0);

        h.name = "post_rst"; h.op = 4'd0; h.x = 8'h01; h.y = 8'h01;
        h.c = 0; h.s = 8'h02; h.co = 0; h.z = 0; h.ov = 0;
        h.il = 0; h.lat = 1;
        run(h, 1'b1);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
